// File: rtl/core_dbg_regfile.sv
// core_dbg_regfile -- debug-port register file for a CPU core.
//
// Register map:
//   0  CTRL    bit0 HALT (level, r/w), bit1 RESUME (write-1 pulse), bit2 STEP
//              (write-1 pulse); everything else reads 0.
//   1  STATUS  read-only; bit0 = core_halted at the access cycle.
//   2.. NUM_REGS-1  scratch registers, byte-strobed read/write.
//
// Optional feature (macro CORE_DBG_ACCESS_CNT_EN): STATUS[31:16] is a
// saturating 16-bit count of accepted, error-free accesses. It is cleared by
// reset or by a CTRL write with byte 3 strobed and bit31 set, and a STATUS
// read returns the count from before that read. The feature needs
// DATA_WIDTH >= 32. With the macro undefined, STATUS[31:16] reads 0 and no
// counter logic is built.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   dbg_req           one-cycle access request
//   dbg_wr_rd         1 = write, 0 = read
//   dbg_addr          register index
//   dbg_wdata         write data
//   dbg_wstrobe       per-byte write enables
//   dbg_rdata         read data; holds its value between reads
//   dbg_rd_ready      one-cycle pulse, one cycle after a read request
//   dbg_err           one-cycle pulse, one cycle after a failed access
//   core_halted       halted status from the core
//   core_halt_req     level halt request (the CTRL.HALT bit)
//   core_resume_req   one-cycle resume pulse
//   core_step_req     one-cycle single-step pulse
module core_dbg_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dbg_req,
    input  logic                    dbg_wr_rd,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_wstrobe,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_rd_ready,
    output logic                    dbg_err,
    input  logic                    core_halted,
    output logic                    core_halt_req,
    output logic                    core_resume_req,
    output logic                    core_step_req
);
    localparam int NB = DATA_WIDTH / 8;

    // Scratch storage only; CTRL keeps just the HALT flop and STATUS is
    // assembled live, so indices 0 and 1 are never allocated.
    logic [DATA_WIDTH-1:0] scratch [2:NUM_REGS-1];
    logic                  halt_q;

    logic in_range, is_ctrl, is_status;
    logic acc_err, acc_ok, wr_ok, rd_req, ctrl_wr;
    logic [DATA_WIDTH-1:0] status_val, rd_val;

    assign in_range  = 32'(dbg_addr) < NUM_REGS;
    assign is_ctrl   = (dbg_addr == '0);
    assign is_status = (dbg_addr == ADDR_WIDTH'(1));

    assign acc_err = dbg_req & (~in_range | (dbg_wr_rd & is_status));
    assign acc_ok  = dbg_req & ~acc_err;
    assign wr_ok   = acc_ok & dbg_wr_rd;
    assign rd_req  = dbg_req & ~dbg_wr_rd;
    assign ctrl_wr = wr_ok & is_ctrl & dbg_wstrobe[0];

    assign core_halt_req = halt_q;

`ifdef CORE_DBG_ACCESS_CNT_EN
    logic [15:0] acc_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr_ok & is_ctrl & dbg_wstrobe[3] & dbg_wdata[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           acc_cnt <= '0;
        else if (cnt_clr)                     acc_cnt <= '0;
        else if (acc_ok && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
    end
`endif

    always_comb begin
        status_val    = '0;
        status_val[0] = core_halted;
`ifdef CORE_DBG_ACCESS_CNT_EN
        status_val[31:16] = acc_cnt;
`endif
    end

    always_comb begin
        rd_val = '0;
        if (in_range) begin
            if (is_ctrl)        rd_val[0] = halt_q;
            else if (is_status) rd_val    = status_val;
            else                rd_val    = scratch[dbg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata       <= '0;
            dbg_rd_ready    <= 1'b0;
            dbg_err         <= 1'b0;
            halt_q          <= 1'b0;
            core_resume_req <= 1'b0;
            core_step_req   <= 1'b0;
            for (int i = 2; i < NUM_REGS; i++) scratch[i] <= '0;
        end else begin
            dbg_rd_ready    <= rd_req;
            dbg_err         <= acc_err;
            core_resume_req <= 1'b0;
            core_step_req   <= 1'b0;
            // Failed reads still complete, returning 0.
            if (rd_req) dbg_rdata <= acc_err ? '0 : rd_val;
            if (ctrl_wr) begin
                halt_q <= dbg_wdata[0];
                // STEP outranks RESUME; RESUME also needs HALT written 0.
                core_step_req   <= dbg_wdata[2] & core_halted;
                core_resume_req <= dbg_wdata[1] & ~dbg_wdata[2] & ~dbg_wdata[0] & core_halted;
            end
            if (wr_ok && !is_ctrl && !is_status) begin
                for (int b = 0; b < NB; b++)
                    if (dbg_wstrobe[b]) scratch[dbg_addr][b*8 +: 8] <= dbg_wdata[b*8 +: 8];
            end
        end
    end
endmodule
